// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter and its lane steering.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: byte enables, write-data replication and read-lane extraction.
module mem_lane_steer
    import mem_pkg::*;
(
    input  logic        is_byte,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    always_comb begin
        be         = BE_WORD;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
        if (is_byte) begin
            be         = 4'b0001 << lane;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {24'h0, rdata_raw[8*lane +: 8]};
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between fetch and data ports onto a single-port memory,
// with fixed wait states and a one-cycle ready pulse per completed access.
module mem_bus_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, next_state;
    logic [3:0]        counter;
    logic              last_grant;
    logic              port_q;
    logic              we_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              any_req;
    logic              grant_port;
    logic              final_cycle;
    logic [3:0]        steer_be;
    logic [31:0]       steer_wdata;
    logic [31:0]       steer_rdata;

    assign any_req     = if_req | d_req;
    assign final_cycle = (state == ACCESS) && (counter == '0);

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        if (if_req && d_req)
            grant_port = ~last_grant;
        else if (d_req)
            grant_port = PORT_D;
        else
            grant_port = PORT_IF;
    end

    mem_lane_steer u_steer (
        .is_byte    (byte_q),
        .lane       (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata_raw  (mem_rdata),
        .be         (steer_be),
        .wdata_lane (steer_wdata),
        .rdata_ext  (steer_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  if (counter == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            last_grant <= PORT_D;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                counter <= WAIT_INIT;
                port_q  <= grant_port;
                if (grant_port == PORT_D) begin
                    we_q    <= d_we;
                    byte_q  <= d_byte;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    we_q    <= 1'b0;
                    byte_q  <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end else if (state == ACCESS && counter != '0) begin
                counter <= counter - 4'd1;
            end
            if (final_cycle) begin
                last_grant <= port_q;
                if (port_q == PORT_D)
                    d_rdata_q <= steer_rdata;
                else
                    if_rdata_q <= steer_rdata;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        busy      = (state != IDLE);
        if (state == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = final_cycle & we_q;
            mem_be    = steer_be;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata = steer_wdata;
        end
        if (state == RESP) begin
            if_ready = (port_q == PORT_IF);
            d_ready  = (port_q == PORT_D);
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: WAIT_CYCLES=2 instance on a small memory
// model, plus a WAIT_CYCLES=0 instance for the minimum-latency case.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, d_byte;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ready, d_ready;
    logic        mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req0;
    logic [31:0] if_addr0;
    logic [31:0] if_rdata0, d_rdata0;
    logic        if_ready0, d_ready0;
    logic        mem_en0, mem_we0, busy0;
    logic [3:0]  mem_be0;
    logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;
    int n_we = 0, n_if = 0, n_d = 0, n_both = 0, n_en0 = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
        .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(32'h0),
        .d_wdata(32'h0), .d_rdata(d_rdata0), .d_ready(d_ready0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
    );

    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_rdata0 = {mem_addr0[15:0], 16'hC0DE};

    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    always @(negedge clk) begin
        if (mem_we) n_we++;
        if (if_ready) n_if++;
        if (d_ready) n_d++;
        if (if_ready && d_ready) n_both++;
        if (mem_en0) n_en0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Waits on negedges for either ready; cyc=-1 if none within the budget.
    task automatic wait_rdy(output int cyc, output int which);
        cyc = -1;
        which = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                cyc = i;
                which = if_ready ? 0 : 1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc, which, we0, d0, cnt;
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; d_byte = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req0 = 0; if_addr0 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h41] = 32'hE3A00001;
        mem[8'h80] = 32'h11223344;
        do_reset();

        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_outs", {28'h0, mem_en, mem_we, busy, if_ready | d_ready}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Fetch-only read.
        we0 = n_we;
        if_req = 1; if_addr = 32'h104;
        wait_rdy(cyc, which);
        if_req = 0;
        check("fetch_lat", 32'(cyc), 32'd4);
        check("fetch_port", 32'(which), 32'd0);
        check("fetch_rdata", if_rdata, 32'hE3A00001);
        check("fetch_no_we", 32'(n_we - we0), 32'd0);

        // Byte write to 0x203.
        @(negedge clk);
        we0 = n_we;
        d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'h203; d_wdata = 32'h000000AB;
        @(negedge clk);
        check("bw_addr", mem_addr, 32'h200);
        check("bw_be", {28'h0, mem_be}, 32'h8);
        check("bw_wdata", mem_wdata, 32'hABABABAB);
        wait_rdy(cyc, which);
        check("bw_lat", 32'(cyc + 1), 32'd4);
        check("bw_we_once", 32'(n_we - we0), 32'd1);
        check("bw_mem", mem[8'h80], 32'hAB223344);

        // Byte read-back, request kept high straight out of RESP.
        d_we = 0; d_byte = 1; d_addr = 32'h203;
        wait_rdy(cyc, which);
        check("br_lat", 32'(cyc), 32'd5);
        check("br_rdata", d_rdata, 32'h000000AB);
        d_byte = 0; d_addr = 32'h200;
        wait_rdy(cyc, which);
        d_req = 0;
        check("wr_rdata", d_rdata, 32'hAB223344);

        // Tie after reset: fetch, then data, then fetch again.
        do_reset();
        cnt = n_both;
        if_req = 1; if_addr = 32'h104; d_req = 1; d_addr = 32'h200;
        wait_rdy(cyc, which);
        if_req = 0;
        check("tie1_port", 32'(which), 32'd0);
        wait_rdy(cyc, which);
        check("tie2_port", 32'(which), 32'd1);
        check("tie2_lat", 32'(cyc), 32'd5);
        if_req = 1;
        wait_rdy(cyc, which);
        check("tie3_port", 32'(which), 32'd0);
        if_req = 0; d_req = 0;
        check("tie_no_overlap", 32'(n_both - cnt), 32'd0);

        // Held data request across RESP gives a second full access.
        @(negedge clk);
        @(negedge clk);
        d0 = n_d;
        d_req = 1; d_addr = 32'h104;
        wait_rdy(cyc, which);
        wait_rdy(cyc, which);
        d_req = 0;
        check("held_lat", 32'(cyc), 32'd5);
        @(negedge clk);
        @(negedge clk);
        check("held_readies", 32'(n_d - d0), 32'd2);
        check("held_rdata", d_rdata, 32'hE3A00001);

        // Reset during the first ACCESS cycle of a word write.
        we0 = n_we;
        d_req = 1; d_we = 1; d_byte = 0; d_addr = 32'h300; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ra_busy", {31'h0, busy}, 32'h1);
        rst = 1; d_req = 0; d_we = 0;
        @(negedge clk);
        check("ra_outs", {28'h0, mem_en, mem_we, busy, if_ready | d_ready}, 32'h0);
        check("ra_addr", mem_addr, 32'h0);
        check("ra_rdata", d_rdata, 32'h0);
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        check("ra_no_we", 32'(n_we - we0), 32'd0);
        check("ra_mem", mem[8'hC0], 32'h0);
        check("ra_idle", {31'h0, busy}, 32'h0);

        // Zero wait states.
        cnt = n_en0;
        if_req0 = 1; if_addr0 = 32'h42;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if_ready0) begin
                cyc = i;
                break;
            end
        end
        if_req0 = 0;
        check("w0_lat", 32'(cyc), 32'd2);
        check("w0_en_cycles", 32'(n_en0 - cnt), 32'd1);
        check("w0_rdata", if_rdata0, 32'h0040C0DE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
